// File: rtl/fpu_shift_pkg.sv
// Shared definitions for the FPU mantissa shifter datapath.
package fpu_shift_pkg;

  localparam int SW_DEF = 26;
  localparam int EW_DEF = 5;
  // One mux level per shift-amount bit
  localparam int LEVELS = EW_DEF;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  // Mask of the low bits that fall off the bottom on a right shift by 2^k.
  // Saturates to all ones once 2^k covers the whole 64-bit mask.
  function automatic logic [63:0] shift_out_mask(input int k);
    int n;
    n = 1 << k;
    if (n >= 64) return '1;
    return (64'd1 << n) - 64'd1;
  endfunction

endpackage

// File: rtl/shift_level.sv
// One barrel-shifter level: conditional shift by 2^K, sticky update,
// overflow tracking and an optional stage register gated by adv.
module shift_level
  import fpu_shift_pkg::*;
#(
  parameter int SW   = 26,
  parameter int EW   = 5,
  parameter int K    = 0,
  parameter bit REG  = 1'b1,
  parameter bit LAST = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          adv,
  input  logic          valid_i,
  input  logic [SW-1:0] data_i,
  input  logic          sticky_i,
  input  logic          dir_i,
  input  logic [EW-1:0] amt_i,
  input  logic          ovf_i,
  output logic          valid_o,
  output logic [SW-1:0] data_o,
  output logic          sticky_o,
  output logic          dir_o,
  output logic [EW-1:0] amt_o,
  output logic          ovf_o
);

  localparam int SH = 1 << K;
  localparam logic [63:0] MASK_W = shift_out_mask(K);
  localparam logic [SW-1:0] MASK = MASK_W[SW-1:0];
  // Shift bits consumed up to and including this level
  localparam int LOW_M = (1 << (K + 1)) - 1;
  localparam logic [31:0] LOW_W = LOW_M;
  localparam logic [EW-1:0] LOW_MASK = LOW_W[EW-1:0];

  logic          take;
  logic [SW-1:0] shl, shr;
  logic [EW-1:0] cum;

  logic          valid_d, sticky_d, dir_d, ovf_d;
  logic [SW-1:0] data_d;
  logic [EW-1:0] amt_d;

  assign take = amt_i[K];
  assign cum  = amt_i & LOW_MASK;

  if (SH >= SW) begin : g_big
    assign shl = '0;
    assign shr = '0;
  end else begin : g_sh
    assign shl = data_i << SH;
    assign shr = data_i >> SH;
  end

  // Next-stage payload: shift, accumulate sticky, flag cumulative overflow
  always_comb begin
    valid_d  = valid_i;
    dir_d    = dir_i;
    amt_d    = amt_i;
    data_d   = data_i;
    sticky_d = sticky_i;
    ovf_d    = ovf_i | (int'(cum) >= SW);
    if (take) begin
      if (dir_i == DIR_LEFT) begin
        data_d = shl;
      end else begin
        data_d   = shr;
        sticky_d = sticky_i | (|(data_i & MASK));
      end
    end
    if (LAST && ovf_d) data_d = '0;
  end

  if (REG) begin : g_reg
    logic          valid_q, sticky_q, dir_q, ovf_q;
    logic [SW-1:0] data_q;
    logic [EW-1:0] amt_q;

    // Stage register: clears on reset, loads only when the pipe advances
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q  <= 1'b0;
        data_q   <= '0;
        sticky_q <= 1'b0;
        dir_q    <= 1'b0;
        amt_q    <= '0;
        ovf_q    <= 1'b0;
      end else if (adv) begin
        valid_q  <= valid_d;
        data_q   <= data_d;
        sticky_q <= sticky_d;
        dir_q    <= dir_d;
        amt_q    <= amt_d;
        ovf_q    <= ovf_d;
      end
    end

    assign valid_o  = valid_q;
    assign data_o   = data_q;
    assign sticky_o = sticky_q;
    assign dir_o    = dir_q;
    assign amt_o    = amt_q;
    assign ovf_o    = ovf_q;
  end else begin : g_comb
    assign valid_o  = valid_d;
    assign data_o   = data_d;
    assign sticky_o = sticky_d;
    assign dir_o    = dir_d;
    assign amt_o    = amt_d;
    assign ovf_o    = ovf_d;
  end

endmodule

// File: rtl/barrel_shifter_norm_pipe.sv
// Pipelined bidirectional barrel shifter with sticky generation and a
// global-stall valid/ready handshake.
module barrel_shifter_norm_pipe
  import fpu_shift_pkg::*;
#(
  parameter int SW   = SW_DEF,
  parameter int EW   = EW_DEF,
  parameter bit PIPE = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic          dir_i,
  input  logic [EW-1:0] shift_amt_i,
  input  logic [SW-1:0] data_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [SW-1:0] data_o,
  output logic          sticky_o
);

  localparam int NLVL = EW;

  logic          adv;
  logic          valid_s  [NLVL+1];
  logic [SW-1:0] data_s   [NLVL+1];
  logic          sticky_s [NLVL+1];
  logic          dir_s    [NLVL+1];
  logic [EW-1:0] amt_s    [NLVL+1];
  logic          ovf_s    [NLVL+1];

  // Whole pipe moves together unless the output is held by the consumer
  assign adv     = !valid_o || ready_i;
  assign ready_o = adv;

  assign valid_s[0]  = valid_i;
  assign data_s[0]   = data_i;
  assign sticky_s[0] = 1'b0;
  assign dir_s[0]    = dir_i;
  assign amt_s[0]    = shift_amt_i;
  assign ovf_s[0]    = 1'b0;

  // Level k handles shift bit k; with PIPE=0 only the last level registers
  for (genvar k = 0; k < NLVL; k++) begin : g_lvl
    shift_level #(
      .SW   (SW),
      .EW   (EW),
      .K    (k),
      .REG  (PIPE || (k == NLVL - 1)),
      .LAST (k == NLVL - 1)
    ) u_lvl (
      .clk      (clk),
      .rst      (rst),
      .adv      (adv),
      .valid_i  (valid_s[k]),
      .data_i   (data_s[k]),
      .sticky_i (sticky_s[k]),
      .dir_i    (dir_s[k]),
      .amt_i    (amt_s[k]),
      .ovf_i    (ovf_s[k]),
      .valid_o  (valid_s[k+1]),
      .data_o   (data_s[k+1]),
      .sticky_o (sticky_s[k+1]),
      .dir_o    (dir_s[k+1]),
      .amt_o    (amt_s[k+1]),
      .ovf_o    (ovf_s[k+1])
    );
  end

  assign valid_o  = valid_s[NLVL];
  assign data_o   = data_s[NLVL];
  assign sticky_o = sticky_s[NLVL];

endmodule

// File: tb/tb_barrel_shifter_norm_pipe.sv
// Randomised and directed bench for barrel_shifter_norm_pipe against an
// arithmetic reference model with an in-order expectation queue.
module tb_barrel_shifter_norm_pipe;

  localparam int SW   = 26;
  localparam int EW   = 5;
  localparam bit PIPE = 1'b1;
  localparam int LAT  = PIPE ? EW : 1;

  typedef struct {
    logic [SW-1:0] d;
    logic          s;
    int            c;
    int            st;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst, valid_i, dir_i, ready_i;
  logic [EW-1:0] shift_amt_i;
  logic [SW-1:0] data_i;
  logic          ready_o, valid_o, sticky_o;
  logic [SW-1:0] data_o;

  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  int   stall_cnt = 0;
  int   out_cnt  = 0;
  int   stall_lo = -1;
  int   stall_hi = -1;
  exp_t q[$];
  logic          held = 1'b0;
  logic [SW-1:0] held_d;
  logic          held_s;

  barrel_shifter_norm_pipe #(.SW(SW), .EW(EW), .PIPE(PIPE)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .dir_i       (dir_i),
    .shift_amt_i (shift_amt_i),
    .data_i      (data_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .data_o      (data_o),
    .sticky_o    (sticky_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: plain arithmetic on a 64-bit copy of the operand
  function automatic exp_t model(input logic dir, input int amt, input logic [SW-1:0] x);
    exp_t r;
    logic [63:0] w, t;
    w = 64'(x);
    r.c = 0;
    r.st = 0;
    if (amt >= SW) begin
      r.d = '0;
      r.s = (dir == 1'b0) ? (x != 0) : 1'b0;
    end else if (dir) begin
      t = w << amt;
      r.d = t[SW-1:0];
      r.s = 1'b0;
    end else begin
      t = w >> amt;
      r.d = t[SW-1:0];
      r.s = (w % (64'd1 << amt)) != 0;
    end
    return r;
  endfunction

  function automatic logic rdy_now();
    return !(cyc >= stall_lo && cyc <= stall_hi);
  endfunction

  task automatic step(input logic r, input logic v, input logic d, input logic [EW-1:0] a,
                      input logic [SW-1:0] x, input logic rdy, output logic acc);
    exp_t e;
    rst = r; valid_i = v; dir_i = d; shift_amt_i = a; data_i = x; ready_i = rdy;
    #2;
    acc = 1'b0;
    if (!r) begin
      if (held) begin
        check("stall_data", 64'(data_o), 64'(held_d));
        check("stall_sticky", 64'(sticky_o), 64'(held_s));
        check("stall_valid", 64'(valid_o), 64'd1);
        held = 1'b0;
      end
      if (valid_o) begin
        if (q.size() == 0) begin
          check("spurious_valid", 64'(valid_o), 64'd0);
        end else if (ready_i) begin
          e = q.pop_front();
          check("data_o", 64'(data_o), 64'(e.d));
          check("sticky_o", 64'(sticky_o), 64'(e.s));
          if (e.st == stall_cnt) check("latency", 64'(cyc - e.c), 64'(LAT));
          out_cnt++;
        end
        if (!ready_i) begin
          check("ready_o_stall", 64'(ready_o), 64'd0);
          held   = 1'b1;
          held_d = data_o;
          held_s = sticky_o;
          stall_cnt++;
        end
      end else begin
        check("ready_o_idle", 64'(ready_o), 64'd1);
      end
      acc = v && ready_o;
      if (acc) begin
        e = model(d, int'(a), x);
        e.c = cyc;
        e.st = stall_cnt;
        q.push_back(e);
      end
    end else begin
      held = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic d, input logic [EW-1:0] a, input logic [SW-1:0] x);
    logic acc;
    int tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 50) begin
      step(1'b0, 1'b1, d, a, x, rdy_now(), acc);
      tries++;
    end
    if (!acc) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    logic acc;
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, acc);
      n++;
    end
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    logic acc;
    int base;
    rst = 1'b1; valid_i = 1'b0; dir_i = 1'b0; shift_amt_i = '0; data_i = '0; ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_valid_o", 64'(valid_o), 64'd0);
    check("rst_data_o", 64'(data_o), 64'd0);
    check("rst_sticky_o", 64'(sticky_o), 64'd0);
    check("rst_ready_o", 64'(ready_o), 64'd1);

    // Directed shifts and boundaries, back to back
    send(1'b0, 5'd4,  26'h3FFFFFF);
    send(1'b1, 5'd25, 26'h0000001);
    send(1'b1, 5'd0,  26'h2A5C3E1);
    send(1'b0, 5'd0,  26'h3FFFFFF);
    send(1'b0, 5'd31, 26'h0000010);
    send(1'b0, 5'd31, 26'h0000000);
    send(1'b1, 5'd31, 26'h3FFFFFF);
    send(1'b0, 5'd26, 26'h2000000);
    send(1'b0, 5'd25, 26'h2000000);
    send(1'b0, 5'd25, 26'h1FFFFFF);
    send(1'b1, 5'd26, 26'h0000001);
    drain();

    // Back-pressure in the middle of an 8-deep stream
    base = out_cnt;
    stall_lo = cyc + 6;
    stall_hi = cyc + 8;
    for (int i = 0; i < 8; i++)
      send(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 26'($urandom));
    stall_lo = -1;
    stall_hi = -1;
    drain();
    check("bp_count", 64'(out_cnt - base), 64'd8);

    // Reset with three transactions in flight
    for (int i = 0; i < 3; i++)
      send(1'b0, 5'($urandom_range(1, 20)), 26'($urandom));
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, acc);
    q.delete();
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, acc);
      check("post_rst_valid", 64'(valid_o), 64'd0);
    end
    send(1'b0, 5'd7, 26'h3C0FFEE);
    drain();

    // Random traffic with random back-pressure
    for (int i = 0; i < 400; i++)
      step(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 31)), 26'($urandom), 1'($urandom_range(0, 3) != 0), acc);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
